// File: rtl/ahb_bus_arbiter_if.sv
// rtl/ahb_bus_arbiter_if.sv - request/grant bundle between AHB masters and the bridge arbiter
interface ahb_bus_arbiter_if #(
  parameter int NUM_MASTERS = 3,
  parameter int MIDX_W      = 2
);
  logic [NUM_MASTERS-1:0] Hbusreq;
  logic [NUM_MASTERS-1:0] Hlock;
  logic [1:0]             Htrans;
  logic                   Hready;
  logic [NUM_MASTERS-1:0] Hgrant;
  logic [MIDX_W-1:0]      Hmaster;
  logic [MIDX_W-1:0]      Hmaster_data;
  logic                   Hmastlock;

  // Requester side: drives requests, muxed transfer type and bridge ready.
  modport master (
    output Hbusreq, Hlock, Htrans, Hready,
    input  Hgrant, Hmaster, Hmaster_data, Hmastlock
  );

  // Arbiter side.
  modport slave (
    input  Hbusreq, Hlock, Htrans, Hready,
    output Hgrant, Hmaster, Hmaster_data, Hmastlock
  );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// rtl/ahb_bus_arbiter.sv - round-robin AHB arbiter with lock and per-tenure beat limit
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 3,
  parameter int MIDX_W         = 2,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_BEATS      = 4
) (
  input logic             Hclk,
  input logic             Hreset,
  ahb_bus_arbiter_if.slave bus
);

  localparam int CNT_W = (MAX_BEATS < 1) ? 1 : $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0]  MAX_C = CNT_W'(MAX_BEATS);
  localparam logic [MIDX_W-1:0] DEF_M = MIDX_W'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] ONE_G = NUM_MASTERS'(1);

  typedef enum logic [1:0] {
    ST_PARK = 2'd0,
    ST_OWN  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  state_t                 r_state;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [MIDX_W-1:0]      r_master;
  logic [MIDX_W-1:0]      r_master_data;
  logic                   r_mastlock;
  logic [CNT_W-1:0]       r_beats;

  state_t                 w_state_nxt;
  logic [MIDX_W-1:0]      w_master_nxt;
  logic [CNT_W-1:0]       w_beats_inc;
  logic [CNT_W-1:0]       w_beats_nxt;
  logic [MIDX_W-1:0]      w_rr_idx;
  logic [NUM_MASTERS-1:0] w_rr_onehot;
  logic                   w_any_req;
  logic                   w_own_req;
  logic                   w_own_lock;
  logic                   w_other_req;
  logic                   w_win_lock;
  logic                   w_active;
  logic                   w_limit;
  int                     w_dist;
  int                     w_best_dist;

  // The grant is one-hot, so masking with it picks out the owner's own bits.
  assign w_any_req   = |bus.Hbusreq;
  assign w_own_req   = |(bus.Hbusreq & r_grant);
  assign w_own_lock  = |(bus.Hlock & r_grant);
  assign w_other_req = |(bus.Hbusreq & ~r_grant);
  assign w_rr_onehot = ONE_G << w_rr_idx;
  assign w_win_lock  = |(bus.Hlock & w_rr_onehot);
  assign w_active    = bus.Htrans[1];

  // Round-robin pick: distance from (owner+1); the owner itself sits at the far end.
  always_comb begin
    w_rr_idx    = DEF_M;
    w_best_dist = NUM_MASTERS;
    w_dist      = 0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      w_dist = (j + NUM_MASTERS - 1 - int'(r_master)) % NUM_MASTERS;
      if (bus.Hbusreq[j] && (w_dist < w_best_dist)) begin
        w_best_dist = w_dist;
        w_rr_idx    = MIDX_W'(j);
      end
    end
  end

  // Beat count including the transfer completing at this edge, saturating.
  always_comb begin
    w_beats_inc = r_beats;
    if (w_active && (r_beats != MAX_C)) begin
      w_beats_inc = r_beats + CNT_W'(1);
    end
  end

  // Next-state and next-owner decision, evaluated at every arbitration point.
  always_comb begin
    w_state_nxt  = r_state;
    w_master_nxt = r_master;
    w_limit      = 1'b0;
    case (r_state)
      ST_PARK: begin
        if (w_any_req) begin
          w_master_nxt = w_rr_idx;
          w_state_nxt  = w_win_lock ? ST_LOCK : ST_OWN;
        end
      end
      ST_OWN, ST_LOCK: begin
        if ((r_state == ST_LOCK) && w_own_lock) begin
          w_state_nxt = ST_LOCK;
        end else begin
          // Leaving a locked tenure counts as an exhausted beat budget.
          w_limit = (MAX_BEATS != 0) && ((r_state == ST_LOCK) || (w_beats_inc == MAX_C));
          if (!w_own_req) begin
            if (w_any_req) begin
              w_master_nxt = w_rr_idx;
              w_state_nxt  = w_win_lock ? ST_LOCK : ST_OWN;
            end else begin
              w_master_nxt = DEF_M;
              w_state_nxt  = ST_PARK;
            end
          end else if (w_limit && w_other_req) begin
            w_master_nxt = w_rr_idx;
            w_state_nxt  = w_win_lock ? ST_LOCK : ST_OWN;
          end else if (w_own_lock) begin
            w_state_nxt = ST_LOCK;
          end else begin
            w_state_nxt = ST_OWN;
          end
        end
      end
      default: begin
        w_master_nxt = DEF_M;
        w_state_nxt  = ST_PARK;
      end
    endcase
  end

  // A new tenure (owner change, or entering/leaving park) restarts the beat budget.
  always_comb begin
    w_beats_nxt = w_beats_inc;
    if ((w_master_nxt != r_master) || (w_state_nxt == ST_PARK) || (r_state == ST_PARK)) begin
      w_beats_nxt = '0;
    end
  end

  // State and output registers; everything holds while the bridge inserts wait states.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      r_state       <= ST_PARK;
      r_grant       <= ONE_G << DEF_M;
      r_master      <= DEF_M;
      r_master_data <= DEF_M;
      r_mastlock    <= 1'b0;
      r_beats       <= '0;
    end else if (bus.Hready) begin
      r_state       <= w_state_nxt;
      r_grant       <= ONE_G << w_master_nxt;
      r_master      <= w_master_nxt;
      r_master_data <= r_master;
      r_mastlock    <= (w_state_nxt == ST_LOCK);
      r_beats       <= w_beats_nxt;
    end
  end

  assign bus.Hgrant       = r_grant;
  assign bus.Hmaster      = r_master;
  assign bus.Hmaster_data = r_master_data;
  assign bus.Hmastlock    = r_mastlock;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb/tb_ahb_bus_arbiter.sv - scoreboard bench for ahb_bus_arbiter
module tb_ahb_bus_arbiter;
  localparam int N  = 3;
  localparam int MW = 2;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NS   = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  logic Hclk = 1'b0;
  logic Hreset;

  ahb_bus_arbiter_if #(.NUM_MASTERS(N), .MIDX_W(MW)) bus ();

  ahb_bus_arbiter #(
    .NUM_MASTERS(N), .MIDX_W(MW), .DEFAULT_MASTER(0), .MAX_BEATS(4)
  ) dut (
    .Hclk   (Hclk),
    .Hreset (Hreset),
    .bus    (bus)
  );

  always #5 Hclk = ~Hclk;

  typedef struct packed {
    logic [N-1:0]  grant;
    logic [MW-1:0] master;
    logic [MW-1:0] mdata;
    logic          mlock;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
  task automatic cycle(input string tag, input logic rst, input logic [N-1:0] req,
                       input logic [N-1:0] lk, input logic [1:0] tr, input logic rdy,
                       input int m, input int md, input logic ml);
    exp_t e;
    logic [N-1:0] one;
    one = 1;
    Hreset      = rst;
    bus.Hbusreq = req;
    bus.Hlock   = lk;
    bus.Htrans  = tr;
    bus.Hready  = rdy;
    e.grant  = one << m;
    e.master = MW'(m);
    e.mdata  = MW'(md);
    e.mlock  = ml;
    exp_q.push_back(e);
    @(posedge Hclk);
    #1;
    e = exp_q.pop_front();
    check({tag, ".grant"}, 32'(bus.Hgrant), 32'(e.grant));
    check({tag, ".master"}, 32'(bus.Hmaster), 32'(e.master));
    check({tag, ".mdata"}, 32'(bus.Hmaster_data), 32'(e.mdata));
    check({tag, ".mlock"}, 32'(bus.Hmastlock), 32'(e.mlock));
  endtask

  initial begin
    int own;
    int nxt;

    // Reset with busy inputs, then park.
    cycle("rst0", 1'b1, 3'b111, 3'b111, T_SEQ, 1'b0, 0, 0, 1'b0);
    cycle("rst1", 1'b1, 3'b101, 3'b010, T_NS, 1'b1, 0, 0, 1'b0);
    cycle("park0", 1'b0, 3'b000, 3'b000, T_IDLE, 1'b1, 0, 0, 1'b0);
    cycle("park1", 1'b0, 3'b000, 3'b000, T_IDLE, 1'b1, 0, 0, 1'b0);

    // Single requester.
    cycle("s1_grant", 1'b0, 3'b010, 3'b000, T_IDLE, 1'b1, 1, 0, 1'b0);
    cycle("s1_data", 1'b0, 3'b010, 3'b000, T_NS, 1'b1, 1, 1, 1'b0);
    cycle("s1_drop", 1'b0, 3'b000, 3'b000, T_IDLE, 1'b1, 0, 1, 1'b0);
    cycle("s1_park", 1'b0, 3'b000, 3'b000, T_IDLE, 1'b1, 0, 0, 1'b0);

    // Round robin with 4-beat tenures: owners 1,2,0,1.
    cycle("rr_start", 1'b0, 3'b111, 3'b000, T_IDLE, 1'b1, 1, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      own = (1 + k) % N;
      nxt = (own + 1) % N;
      for (int j = 0; j < 4; j++) begin
        cycle($sformatf("rr_o%0d_b%0d", own, j), 1'b0, 3'b111, 3'b000,
              (j == 0) ? T_NS : T_SEQ, 1'b1, (j < 3) ? own : nxt, own, 1'b0);
      end
    end

    // Wait states mid-tenure of master 1.
    cycle("ws_b1", 1'b0, 3'b111, 3'b000, T_NS, 1'b1, 1, 1, 1'b0);
    cycle("ws_b2", 1'b0, 3'b111, 3'b000, T_SEQ, 1'b1, 1, 1, 1'b0);
    for (int j = 0; j < 3; j++) begin
      cycle($sformatf("ws_hold%0d", j), 1'b0, 3'b111, 3'b000, T_SEQ, 1'b0, 1, 1, 1'b0);
    end
    cycle("ws_b3", 1'b0, 3'b111, 3'b000, T_SEQ, 1'b1, 1, 1, 1'b0);
    cycle("ws_b4", 1'b0, 3'b111, 3'b000, T_SEQ, 1'b1, 2, 1, 1'b0);

    // Locked tenure of master 2 ignores the beat limit.
    cycle("lk_enter", 1'b0, 3'b111, 3'b100, T_NS, 1'b1, 2, 2, 1'b1);
    for (int j = 0; j < 10; j++) begin
      cycle($sformatf("lk_hold%0d", j), 1'b0, 3'b111, 3'b100, T_SEQ, 1'b1, 2, 2, 1'b1);
    end
    cycle("lk_leave", 1'b0, 3'b111, 3'b000, T_SEQ, 1'b1, 0, 2, 1'b0);

    // Owner drop hands to 1, then reset during a wait state.
    cycle("rm_grant", 1'b0, 3'b010, 3'b000, T_NS, 1'b1, 1, 0, 1'b0);
    cycle("rm_rst", 1'b1, 3'b010, 3'b010, T_SEQ, 1'b0, 0, 0, 1'b0);
    cycle("rm_park", 1'b0, 3'b000, 3'b000, T_IDLE, 1'b1, 0, 0, 1'b0);

    // Default master requesting a lock leaves park.
    cycle("dm_lock", 1'b0, 3'b001, 3'b001, T_IDLE, 1'b1, 0, 0, 1'b1);
    cycle("dm_hold", 1'b0, 3'b001, 3'b001, T_NS, 1'b1, 0, 0, 1'b1);
    cycle("dm_rel", 1'b0, 3'b000, 3'b000, T_IDLE, 1'b1, 0, 0, 1'b0);

    // No arbitration while Hready is low, even in park.
    cycle("pk_hold", 1'b0, 3'b010, 3'b000, T_IDLE, 1'b0, 0, 0, 1'b0);
    cycle("pk_go", 1'b0, 3'b010, 3'b000, T_IDLE, 1'b1, 1, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
